add_sub_issue_scheduler: RTL and testbench
==========================================

// Module: add_sub_issue_scheduler
//
// PURPOSE
//   Round-robin issue scheduler in front of the 4-stage add/sub execution unit.
//   Arbitrates NUM_REQ reservation-station issue ports, registers the winner
//   into one output slot, and drives the unit's valid/ready input handshake.
//   Credit-limits outstanding operations so the unit and writeback never back up.
//
// PARAMETERS
//   NUM_REQ       4  number of requesting RS issue ports (>=2)
//   RS_ID_WIDTH   5  width of RS entry id, matches execution unit
//   MAX_INFLIGHT  4  max ops accepted but not yet retired (>=1)
//
// PORTS
//   clk               in   1                  clock
//   rst               in   1                  sync active-high reset
//   req_valid         in   [0:NUM_REQ-1]      requester i has an op
//   req_ready         out  [0:NUM_REQ-1]      requester i accepted this cycle (one-hot or zero)
//   req_rs_id         in   [0:NUM_REQ-1][0:RS_ID_WIDTH-1]  per-requester RS id
//   req_result_addr   in   [0:NUM_REQ-1][0:4] per-requester dest GPR
//   req_op1/req_op2   in   [0:NUM_REQ-1][0:31] per-requester operands
//   req_carry         in   [0:NUM_REQ-1]      per-requester XER[CA] in
//   req_control       in   add_sub_decode_t[0:NUM_REQ-1]  per-requester decode
//   flush             in   1                  drop the staged (unissued) op
//   unit_valid        out  1                  to unit input_valid
//   unit_ready        in   1                  from unit input_ready
//   unit_rs_id        out  RS_ID_WIDTH        to unit rs_id_in
//   unit_result_addr  out  5                  to unit result_reg_addr_in
//   unit_op1/op2      out  32 each            to unit op1/op2
//   unit_carry        out  1                  to unit carry_in
//   unit_control      out  add_sub_decode_t   to unit control
//   retire            in   1                  unit output_valid & output_ready
//   inflight_cnt      out  $clog2(MAX_INFLIGHT+1)  ops accepted, not retired
//
// BEHAVIOUR
//   - Reset (rst=1, sync): unit_valid=0, all unit_* data=0, inflight_cnt=0,
//     rr_ptr=0; req_ready forced 0 while rst=1.
//   - Slot free = ~unit_valid | unit_ready. Credit ok = inflight_cnt < MAX_INFLIGHT.
//   - Accept when slot free & credit ok & ~flush & |req_valid: winner = first
//     valid index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ; req_ready[winner]=1
//     (combinational), slot loads its fields, unit_valid=1 next cycle.
//   - rr_ptr <= (winner+1) mod NUM_REQ on accept only; unchanged otherwise.
//   - Latency: request accepted in cycle N is on unit_* in cycle N+1.
//     Back-to-back accepts sustain 1 op/cycle while unit_ready=1.
//   - Slot holds stable while unit_valid & ~unit_ready; no requester is acked.
//   - Slot drains (unit_valid<=0) on unit handshake with no new accept.
//   - inflight_cnt: +1 on accept, -1 on retire, unchanged if both in same cycle.
//     Retire at inflight_cnt=0 is ignored (count saturates at 0, assertion fires).
//   - flush: unit_valid<=0, no accept that cycle, inflight_cnt -= 1 if slot held
//     an op not handshaken this cycle. Flush with simultaneous unit handshake:
//     op counts as issued (no decrement), slot cleared. Retire still applies.
//   - rst mid-operation clears state immediately; in-flight ops in the unit are
//     the owner's responsibility (unit is reset on the same rst).
//
// CONFIGURATION
//   ADD_SUB_SCHED_STATS_EN defined: adds outputs issue_count[0:31] (+1 per unit
//     handshake) and stall_count[0:31] (+1 per cycle with |req_valid and no
//     accept); both reset to 0, wrap at 2^32.
//   Undefined: those ports and counters do not exist; behaviour otherwise identical.
//
// TESTING
//   - Reset: assert rst with req_valid=4'b1111 -> req_ready=0, unit_valid=0, inflight_cnt=0.
//   - Fairness: req_valid=4'b1111 constant, unit_ready=1, retire every cycle ->
//     grants 0,1,2,3,0 in successive cycles, unit_rs_id follows.
//   - Backpressure: unit_ready=0 for 3 cycles with op in slot -> unit_* stable,
//     req_ready=0; unit_ready=1 -> next op loads same cycle.
//   - Credit: MAX_INFLIGHT=4, no retire -> 4 accepts then req_ready=0;
//     one retire -> exactly one more accept; accept+retire same cycle -> cnt stays.
//   - Flush: slot full, inflight_cnt=2, unit_ready=0, flush=1 -> unit_valid=0,
//     inflight_cnt=1, no req_ready that cycle.
//   - Stats (macro on): 10 handshakes, 3 stalled cycles -> issue_count=10, stall_count=3.

Source files
------------

// File: rtl/add_sub_issue_scheduler_if.sv
// Issue-port bundle: NUM_REQ reservation-station requesters, the staged slot toward the add/sub unit, credits.
// Optional ADD_SUB_SCHED_STATS_EN adds the issue_count/stall_count counters.
interface add_sub_issue_scheduler_if #(
  parameter int NUM_REQ      = 4,
  parameter int RS_ID_WIDTH  = 5,
  parameter int MAX_INFLIGHT = 4
);
  typedef struct packed {
    logic subtract;
    logic use_carry;
    logic invert_op1;
    logic set_overflow;
    logic record;
  } add_sub_decode_t;

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [RS_ID_WIDTH-1:0] req_rs_id       [NUM_REQ];
  logic [4:0]             req_result_addr [NUM_REQ];
  logic [31:0]            req_op1         [NUM_REQ];
  logic [31:0]            req_op2         [NUM_REQ];
  logic [NUM_REQ-1:0]     req_carry;
  add_sub_decode_t        req_control     [NUM_REQ];
  logic                   flush;

  logic                   unit_valid;
  logic                   unit_ready;
  logic [RS_ID_WIDTH-1:0] unit_rs_id;
  logic [4:0]             unit_result_addr;
  logic [31:0]            unit_op1;
  logic [31:0]            unit_op2;
  logic                   unit_carry;
  add_sub_decode_t        unit_control;
  logic                   retire;
  logic [CNT_W-1:0]       inflight_cnt;
`ifdef ADD_SUB_SCHED_STATS_EN
  logic [31:0]            issue_count;
  logic [31:0]            stall_count;
`endif

  modport master (
    input  req_valid, req_rs_id, req_result_addr, req_op1, req_op2, req_carry, req_control,
    input  flush, unit_ready, retire,
    output req_ready, unit_valid, unit_rs_id, unit_result_addr, unit_op1, unit_op2,
    output unit_carry, unit_control, inflight_cnt
`ifdef ADD_SUB_SCHED_STATS_EN
    , output issue_count, stall_count
`endif
  );

  modport slave (
    output req_valid, req_rs_id, req_result_addr, req_op1, req_op2, req_carry, req_control,
    output flush, unit_ready, retire,
    input  req_ready, unit_valid, unit_rs_id, unit_result_addr, unit_op1, unit_op2,
    input  unit_carry, unit_control, inflight_cnt
`ifdef ADD_SUB_SCHED_STATS_EN
    , input issue_count, stall_count
`endif
  );
endinterface

// File: rtl/add_sub_issue_scheduler.sv
// Round-robin credit-limited issue scheduler for the add/sub unit; accepted op appears on unit_* one cycle later.
// Slot holds while unit_ready=0 (no acks); ADD_SUB_SCHED_STATS_EN enables issue/stall counters.
module add_sub_issue_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int RS_ID_WIDTH  = 5,
  parameter int MAX_INFLIGHT = 4
) (
  input logic                      clk,
  input logic                      rst,
  add_sub_issue_scheduler_if.master bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] scan_idx;
  logic          win_found;
  logic          slot_free;
  logic          credit_ok;
  logic          accept;
  logic          handshake;
  logic          slot_drop;
  logic          retire_ok;
  logic [CW:0]   cnt_up;
  logic [CW:0]   cnt_dn;
  logic [CW-1:0] cnt_next;

  assign slot_free = ~bus.unit_valid | bus.unit_ready;
  assign credit_ok = bus.inflight_cnt < CW'(MAX_INFLIGHT);
  assign handshake = bus.unit_valid & bus.unit_ready;
  assign accept    = ~rst & slot_free & credit_ok & ~bus.flush & win_found;
  // A flushed op that never handshook gives its credit back.
  assign slot_drop = bus.flush & bus.unit_valid & ~bus.unit_ready;
  assign retire_ok = bus.retire & (bus.inflight_cnt != '0);

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!win_found && bus.req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[win_idx] = 1'b1;
  end

  assign cnt_up   = {1'b0, bus.inflight_cnt} + (CW+1)'(accept);
  assign cnt_dn   = (CW+1)'(retire_ok) + (CW+1)'(slot_drop);
  assign cnt_next = (cnt_up > cnt_dn) ? CW'(cnt_up - cnt_dn) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr               <= '0;
      bus.unit_valid       <= 1'b0;
      bus.unit_rs_id       <= '0;
      bus.unit_result_addr <= '0;
      bus.unit_op1         <= '0;
      bus.unit_op2         <= '0;
      bus.unit_carry       <= 1'b0;
      bus.unit_control     <= '0;
      bus.inflight_cnt     <= '0;
`ifdef ADD_SUB_SCHED_STATS_EN
      bus.issue_count      <= '0;
      bus.stall_count      <= '0;
`endif
    end else begin
      assert (!(bus.retire && bus.inflight_cnt == '0));
      if (accept) begin
        bus.unit_valid       <= 1'b1;
        bus.unit_rs_id       <= bus.req_rs_id[win_idx];
        bus.unit_result_addr <= bus.req_result_addr[win_idx];
        bus.unit_op1         <= bus.req_op1[win_idx];
        bus.unit_op2         <= bus.req_op2[win_idx];
        bus.unit_carry       <= bus.req_carry[win_idx];
        bus.unit_control     <= bus.req_control[win_idx];
        rr_ptr               <= (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end else if (bus.flush || handshake) begin
        bus.unit_valid <= 1'b0;
      end
      bus.inflight_cnt <= cnt_next;
`ifdef ADD_SUB_SCHED_STATS_EN
      bus.issue_count <= bus.issue_count + 32'(handshake);
      bus.stall_count <= bus.stall_count + 32'((|bus.req_valid) & ~accept);
`endif
    end
  end
endmodule

// File: tb/tb_add_sub_issue_scheduler.sv
// Directed + random bench for add_sub_issue_scheduler against an occupancy-based reference model.
module tb_add_sub_issue_scheduler;
  localparam int NR   = 4;
  localparam int IDW  = 5;
  localparam int MAXI = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  add_sub_issue_scheduler_if #(.NUM_REQ(NR), .RS_ID_WIDTH(IDW), .MAX_INFLIGHT(MAXI)) bus ();
  add_sub_issue_scheduler #(.NUM_REQ(NR), .RS_ID_WIDTH(IDW), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: staged slot contents, ops issued to the unit but not retired, rotation start.
  logic [79:0] d_fields [NR];
  logic        m_valid  = 1'b0;
  logic [79:0] m_fields = '0;
  int          in_unit  = 0;
  int          m_ptr    = 0;
  logic [31:0] m_issue  = '0;
  logic [31:0] m_stall  = '0;

  logic [NR-1:0] s_ready;
  logic [2:0]    s_cnt;
  logic          s_valid;
  logic [79:0]   s_fields;
  logic [79:0]   held;
  logic          want_retire;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [79:0] f);
    d_fields[i]             = f;
    bus.req_rs_id[i]        = f[79:75];
    bus.req_result_addr[i]  = f[74:70];
    bus.req_op1[i]          = f[69:38];
    bus.req_op2[i]          = f[37:6];
    bus.req_carry[i]        = f[5];
    bus.req_control[i]      = f[4:0];
  endtask

  function automatic logic [79:0] rand_fields();
    return {$urandom, $urandom, 16'($urandom)};
  endfunction

  task automatic step();
    logic          slot_free;
    logic          accept;
    logic          hs;
    int            win;
    int            idx;
    logic [NR-1:0] exp_ready;
    logic [4:0]    ctl;
    bus.retire = want_retire && in_unit > 0 && !rst;
    @(negedge clk);
    slot_free = !m_valid || bus.unit_ready;
    accept = !rst && slot_free && (in_unit + int'(m_valid)) < MAXI && !bus.flush && (|bus.req_valid);
    win = 0;
    for (int k = NR - 1; k >= 0; k--) begin
      idx = (m_ptr + k) % NR;
      if (bus.req_valid[idx]) win = idx;
    end
    exp_ready = '0;
    if (accept) exp_ready[win] = 1'b1;
    ctl      = bus.unit_control;
    s_ready  = bus.req_ready;
    s_cnt    = bus.inflight_cnt;
    s_valid  = bus.unit_valid;
    s_fields = {bus.unit_rs_id, bus.unit_result_addr, bus.unit_op1, bus.unit_op2, bus.unit_carry, ctl};
    chk("req_ready", 80'(s_ready), 80'(exp_ready));
    chk("unit_valid", 80'(s_valid), 80'(m_valid));
    chk("inflight_cnt", 80'(s_cnt), 80'(in_unit + int'(m_valid)));
    chk("unit_fields", s_fields, m_fields);
`ifdef ADD_SUB_SCHED_STATS_EN
    chk("issue_count", 80'(bus.issue_count), 80'(m_issue));
    chk("stall_count", 80'(bus.stall_count), 80'(m_stall));
`endif
    @(posedge clk);
    if (rst) begin
      m_valid  = 1'b0;
      m_fields = '0;
      in_unit  = 0;
      m_ptr    = 0;
      m_issue  = '0;
      m_stall  = '0;
    end else begin
      hs = m_valid && bus.unit_ready;
      if (bus.retire && in_unit > 0) in_unit--;
      if (hs) in_unit++;
      m_issue = m_issue + 32'(hs);
      if ((|bus.req_valid) && !accept) m_stall = m_stall + 32'd1;
      if (accept) begin
        m_valid  = 1'b1;
        m_fields = d_fields[win];
        m_ptr    = (win + 1) % NR;
      end else if (bus.flush || hs) begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    logic [79:0] f;
    rst            = 1'b1;
    bus.req_valid  = '1;
    bus.unit_ready = 1'b0;
    bus.flush      = 1'b0;
    bus.retire     = 1'b0;
    want_retire    = 1'b0;
    for (int i = 0; i < NR; i++) begin
      f = rand_fields();
      f[79:75] = 5'(i);
      set_req(i, f);
    end

    step();
    step();
    chk("rst_req_ready", 80'(s_ready), 80'd0);
    chk("rst_unit_valid", 80'(s_valid), 80'd0);
    chk("rst_inflight", 80'(s_cnt), 80'd0);

    // Fairness: everyone requesting, unit always ready, retire as fast as ops arrive.
    rst            = 1'b0;
    bus.unit_ready = 1'b1;
    want_retire    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("fair_grant", 80'(s_ready), 80'(4'b0001 << (k % NR)));
      if (k > 0) chk("fair_rs_id", 80'(s_fields[79:75]), 80'((k - 1) % NR));
    end

    // Backpressure: slot must hold and no requester is acked.
    bus.unit_ready = 1'b0;
    step();
    held = s_fields;
    chk("bp_ready", 80'(s_ready), 80'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("bp_ready", 80'(s_ready), 80'd0);
      chk("bp_hold", s_fields, held);
    end
    bus.unit_ready = 1'b1;
    step();
    chk("bp_release", 80'(s_ready), 80'(4'b0010));

    // Credit exhaustion with no retires.
    want_retire = 1'b0;
    for (int k = 0; k < 6; k++) step();
    chk("credit_full_cnt", 80'(s_cnt), 80'd4);
    chk("credit_block", 80'(s_ready), 80'd0);
    want_retire = 1'b1;
    step();
    chk("credit_retire_blk", 80'(s_ready), 80'd0);
    step();
    chk("credit_one_more", 80'(s_ready != '0), 80'd1);
    chk("credit_cnt3", 80'(s_cnt), 80'd3);
    want_retire = 1'b0;
    step();
    chk("acc_ret_same_cnt", 80'(s_cnt), 80'd3);
    step();
    chk("credit_full_again", 80'(s_ready), 80'd0);

    // Drain, then stage an op with one already issued and flush it.
    bus.req_valid = '0;
    want_retire   = 1'b1;
    for (int n = 0; n < 20 && (in_unit > 0 || m_valid); n++) step();
    step();
    chk("drained_cnt", 80'(s_cnt), 80'd0);
    want_retire   = 1'b0;
    bus.req_valid = '1;
    step();
    step();
    bus.unit_ready = 1'b0;
    bus.flush      = 1'b1;
    step();
    chk("flush_cnt_before", 80'(s_cnt), 80'd2);
    chk("flush_no_ready", 80'(s_ready), 80'd0);
    bus.flush     = 1'b0;
    bus.req_valid = '0;
    step();
    chk("flush_valid", 80'(s_valid), 80'd0);
    chk("flush_cnt_after", 80'(s_cnt), 80'd1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      rst            = ($urandom_range(99) == 0);
      bus.req_valid  = NR'($urandom);
      bus.unit_ready = ($urandom_range(3) != 0);
      bus.flush      = ($urandom_range(15) == 0);
      want_retire    = ($urandom_range(2) != 0);
      for (int i = 0; i < NR; i++) set_req(i, rand_fields());
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
